// File: rtl/conv_seq_ctrl_if.sv
// Start/count request and enable-vector response bundle between the job issuer and the
// convolution sequencer.
interface conv_seq_ctrl_if;
  logic        start;
  logic [7:0]  num_chnl;
  logic [15:0] num_tile;
  logic [31:0] state;
  logic        busy;
  logic        done;

  modport master (
    output start, num_chnl, num_tile,
    input  state, busy, done
  );

  modport slave (
    input  start, num_chnl, num_tile,
    output state, busy, done
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution datapath sequencer: walks every channel of every tile through the fixed read,
// compute, accumulate and write-out phases, driving a registered one-hot-ish enable vector.
module conv_seq_ctrl #(
  parameter int unsigned IFM_WORDS = 4,
  parameter int unsigned WHT_WORDS = 2,
  parameter int unsigned P2S_WORDS = 7
) (
  input logic           clk,
  input logic           rst_n,
  conv_seq_ctrl_if.slave bus
);

  localparam int unsigned MaxRdWords = (IFM_WORDS > WHT_WORDS) ? IFM_WORDS : WHT_WORDS;
  localparam int unsigned MaxWords   = (MaxRdWords > P2S_WORDS) ? MaxRdWords : P2S_WORDS;
  localparam int unsigned CntW       = (MaxWords > 1) ? $clog2(MaxWords) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t IfmLast = cnt_t'(IFM_WORDS - 1);
  localparam cnt_t WhtLast = cnt_t'(WHT_WORDS - 1);
  localparam cnt_t P2sLast = cnt_t'(P2S_WORDS - 1);

  typedef enum logic [3:0] {
    StIdle, StIfmRd, StWhtRd, StDrain, StPe, StPa, StBa, StCa,
    StRelu, StP2sWr, StP2sRd, StDone
  } fsm_e;

  fsm_e        fsm_q, fsm_d;
  cnt_t        word_q, word_d;
  logic [7:0]  chnl_q, chnl_d, nchnl_q, nchnl_d;
  logic [15:0] tile_q, tile_d, ntile_q, ntile_d;
  logic [12:0] dp_q, dp_d;
  logic        busy_q, done_q;

  function automatic logic [12:0] decode(fsm_e s);
    logic [12:0] v;
    v = '0;
    unique case (s)
      StIfmRd: v[0]     = 1'b1;
      StWhtRd: v[1]     = 1'b1;
      StPe:    v[3:2]   = 2'b11;
      StPa:    v[7:6]   = 2'b11;
      StBa:    v[8]     = 1'b1;
      StCa:    v[9]     = 1'b1;
      StRelu:  v[10]    = 1'b1;
      StP2sWr: v[11]    = 1'b1;
      StP2sRd: v[12]    = 1'b1;
      default: v        = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    fsm_d   = fsm_q;
    word_d  = word_q;
    chnl_d  = chnl_q;
    tile_d  = tile_q;
    nchnl_d = nchnl_q;
    ntile_d = ntile_q;
    unique case (fsm_q)
      StIdle: begin
        if (bus.start) begin
          nchnl_d = bus.num_chnl;
          ntile_d = bus.num_tile;
          chnl_d  = '0;
          tile_d  = '0;
          word_d  = '0;
          fsm_d   = (bus.num_chnl == 8'd0 || bus.num_tile == 16'd0) ? StDone : StIfmRd;
        end
      end
      StIfmRd: begin
        if (word_q == IfmLast) begin
          word_d = '0;
          fsm_d  = StWhtRd;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      StWhtRd: begin
        if (word_q == WhtLast) begin
          word_d = '0;
          fsm_d  = StDrain;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      StDrain: fsm_d = StPe;
      StPe:    fsm_d = StPa;
      StPa:    fsm_d = StBa;
      StBa:    fsm_d = StCa;
      StCa: begin
        // Sampled count is >= 1 here, so the minus one cannot underflow.
        if (chnl_q != nchnl_q - 8'd1) begin
          chnl_d = chnl_q + 8'd1;
          fsm_d  = StIfmRd;
        end else begin
          chnl_d = '0;
          fsm_d  = StRelu;
        end
      end
      StRelu:  fsm_d = StP2sWr;
      StP2sWr: begin
        word_d = '0;
        fsm_d  = StP2sRd;
      end
      StP2sRd: begin
        if (word_q == P2sLast) begin
          word_d = '0;
          if (tile_q != ntile_q - 16'd1) begin
            tile_d = tile_q + 16'd1;
            fsm_d  = StIfmRd;
          end else begin
            fsm_d  = StDone;
          end
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      StDone:  fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // Bits 4/5 echo the previous cycle's read strobes to model SRAM read latency.
  always_comb begin
    dp_d    = decode(fsm_d);
    dp_d[4] = dp_q[0];
    dp_d[5] = dp_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      word_q  <= '0;
      chnl_q  <= '0;
      tile_q  <= '0;
      nchnl_q <= '0;
      ntile_q <= '0;
      dp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      word_q  <= word_d;
      chnl_q  <= chnl_d;
      tile_q  <= tile_d;
      nchnl_q <= nchnl_d;
      ntile_q <= ntile_d;
      dp_q    <= dp_d;
      busy_q  <= (fsm_d != StIdle);
      done_q  <= (fsm_d == StDone);
    end
  end

  assign bus.state = {19'b0, dp_q};
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: a timeline model of each accepted job checked every cycle, plus
// hand-computed cycle-offset expectations for the directed scenarios.
module tb_conv_seq_ctrl;

  localparam int unsigned IfmW = 4;
  localparam int unsigned WhtW = 2;
  localparam int unsigned P2sW = 7;

  logic clk;
  logic rst_n;
  logic check_en;
  int   total;
  int   bad;

  conv_seq_ctrl_if bus ();

  conv_seq_ctrl #(
    .IFM_WORDS (IfmW),
    .WHT_WORDS (WhtW),
    .P2S_WORDS (P2sW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] st;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;

  logic [31:0] st_tr [0:127];
  logic        bs_tr [0:127];
  logic        dn_tr [0:127];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Expected per-cycle timeline of a job, starting the cycle after it is accepted.
  task automatic build_job(input int c, input int t);
    logic [31:0] base [$];
    logic [31:0] prev;
    if (c != 0 && t != 0) begin
      for (int ti = 0; ti < t; ti++) begin
        for (int ch = 0; ch < c; ch++) begin
          for (int w = 0; w < IfmW; w++) base.push_back(32'h1);
          for (int w = 0; w < WhtW; w++) base.push_back(32'h2);
          base.push_back(32'h0);
          base.push_back(32'h0C);
          base.push_back(32'hC0);
          base.push_back(32'h100);
          base.push_back(32'h200);
        end
        base.push_back(32'h400);
        base.push_back(32'h800);
        for (int w = 0; w < P2sW; w++) base.push_back(32'h1000);
      end
    end
    prev = '0;
    foreach (base[i]) begin
      exp_q.push_back('{st: base[i] | {26'b0, prev[1], prev[0], 4'b0}, busy: 1'b1, done: 1'b0});
      prev = base[i];
    end
    exp_q.push_back('{st: {26'b0, prev[1], prev[0], 4'b0}, busy: 1'b1, done: 1'b1});
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (check_en && !clk) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("model_state", bus.state, e.st);
      chk("model_busy", {31'b0, bus.busy}, {31'b0, e.busy});
      chk("model_done", {31'b0, bus.done}, {31'b0, e.done});
      if (!e.busy && bus.start) build_job(int'(bus.num_chnl), int'(bus.num_tile));
    end
  end

  // Start high for the one cycle that ends at edge k; returns inside cycle k+1.
  task automatic pulse(input int c, input int t);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.num_chnl = 8'(c);
    bus.num_tile = 16'(t);
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // Records cycles k+1..k+n; optionally re-asserts start over [s0,s1] or resets in cycle rst_at.
  task automatic trace_run(input int n, input int s0, input int s1, input int rst_at);
    for (int m = 1; m <= n; m++) begin
      @(negedge clk);
      st_tr[m] = bus.state;
      bs_tr[m] = bus.busy;
      dn_tr[m] = bus.done;
      if (m == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", bus.state, 32'h0);
        chk("async_rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("async_rst_done", {31'b0, bus.done}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.start = (m + 1 >= s0) && (m + 1 <= s1);
    end
    bus.start = 1'b0;
  endtask

  function automatic int count_bit(input int n, input int b);
    int cnt;
    cnt = 0;
    for (int m = 1; m <= n; m++) if (st_tr[m][b]) cnt++;
    return cnt;
  endfunction

  initial begin
    int nd;
    total        = 0;
    bad          = 0;
    check_en     = 1'b0;
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.num_chnl = 8'd0;
    bus.num_tile = 16'd0;
    for (int i = 0; i < 128; i++) begin
      st_tr[i] = '0;
      bs_tr[i] = 1'b0;
      dn_tr[i] = 1'b0;
    end

    // Reset held with start asserted.
    #2 rst_n = 1'b0;
    bus.start    = 1'b1;
    bus.num_chnl = 8'd1;
    bus.num_tile = 16'd1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", bus.state, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_done", {31'b0, bus.done}, 32'h0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst_n     = 1'b1;
    check_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {bus.state[30:0], bus.busy}, 32'h0);

    // Single job C=1 T=1.
    pulse(1, 1);
    trace_run(24, 0, 0, 0);
    chk("s_k1", st_tr[1], 32'h1);
    chk("s_k2", st_tr[2], 32'h11);
    chk("s_k4", st_tr[4], 32'h11);
    chk("s_k5", st_tr[5], 32'h12);
    chk("s_k6", st_tr[6], 32'h22);
    chk("s_k7", st_tr[7], 32'h20);
    chk("s_k8", st_tr[8], 32'h0C);
    chk("s_k9", st_tr[9], 32'hC0);
    chk("s_k10", st_tr[10], 32'h100);
    chk("s_k11", st_tr[11], 32'h200);
    chk("s_k12", st_tr[12], 32'h400);
    chk("s_k13", st_tr[13], 32'h800);
    chk("s_k14", st_tr[14], 32'h1000);
    chk("s_k20", st_tr[20], 32'h1000);
    chk("s_done_k20", {31'b0, dn_tr[20]}, 32'h0);
    chk("s_done_k21", {31'b0, dn_tr[21]}, 32'h1);
    chk("s_busy_k21", {31'b0, bs_tr[21]}, 32'h1);
    chk("s_busy_k22", {31'b0, bs_tr[22]}, 32'h0);

    // Multi-channel / multi-tile C=2 T=3.
    pulse(2, 3);
    trace_run(100, 0, 0, 0);
    chk("m_bit9_pulses", 32'(count_bit(100, 9)), 32'd6);
    chk("m_bit10_pulses", 32'(count_bit(100, 10)), 32'd3);
    chk("m_bit12_cycles", 32'(count_bit(100, 12)), 32'd21);
    chk("m_done_k94", {31'b0, dn_tr[94]}, 32'h1);
    nd = 0;
    for (int m = 1; m <= 100; m++) if (dn_tr[m]) nd++;
    chk("m_done_count", 32'(nd), 32'd1);

    // Zero channels: straight to DONE; start in DONE is dropped, start right after is taken.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.num_chnl = 8'd0;
    bus.num_tile = 16'd5;
    @(posedge clk); #1;
    bus.num_chnl = 8'd1;
    bus.num_tile = 16'd1;
    @(negedge clk);
    chk("z_done_k1", {31'b0, bus.done}, 32'h1);
    chk("z_state_k1", bus.state, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_idle_k2", {bus.state[30:0], bus.busy}, 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("z_restart_k3", bus.state, 32'h1);
    repeat (25) @(posedge clk);

    // Start while busy is dropped.
    pulse(1, 1);
    trace_run(24, 10, 10, 0);
    chk("b_done_k21", {31'b0, dn_tr[21]}, 32'h1);
    chk("b_busy_k22", {31'b0, bs_tr[22]}, 32'h0);
    chk("b_idle_k24", st_tr[24], 32'h0);

    // Reset during PA, then a full job.
    pulse(2, 1);
    trace_run(30, 0, 0, 9);
    chk("r_pa_k9", st_tr[9], 32'hC0);
    repeat (4) @(posedge clk);
    pulse(1, 2);
    trace_run(45, 0, 0, 0);
    chk("r_done_k41", {31'b0, dn_tr[41]}, 32'h1);
    chk("r_bit12_cycles", 32'(count_bit(45, 12)), 32'd14);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
